// File: rtl/mm_arb.sv
// -----------------------------------------------------------------------------
// mm_arb : two-requester line arbiter in front of a single memory port.
//
// Requesters 0 and 1 issue line fills (read) or evictions (write). The
// arbiter picks one round-robin in IDLE, latches its command, presents it
// to memory in ISSUE until mm_ready, then for reads waits for the response
// in WAIT_RD under a watchdog. Only one memory transaction is ever in flight.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   cN_a / cN_read / cN_write   requester N address and command (held)
//   cN_writedata                requester N eviction data
//   cN_ready                    pulse: requester N command accepted by memory
//   cN_readdata(_valid)         fill data / pulse for requester N
//   mm_a / mm_read / mm_write   memory command
//   mm_writedata                memory write data
//   mm_readdata(_valid)         memory read response
//   mm_ready                    memory accepts the command this cycle
//   busy                        arbiter not in IDLE
//   err                         pulse: watchdog timeout or stray response
// -----------------------------------------------------------------------------
module mm_arb #(
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned MAX_WAIT  = 255
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [31:0]          c0_a,
  input  logic                 c0_read,
  input  logic                 c0_write,
  input  logic [LINE_BITS-1:0] c0_writedata,
  output logic                 c0_ready,
  output logic [LINE_BITS-1:0] c0_readdata,
  output logic                 c0_readdata_valid,

  input  logic [31:0]          c1_a,
  input  logic                 c1_read,
  input  logic                 c1_write,
  input  logic [LINE_BITS-1:0] c1_writedata,
  output logic                 c1_ready,
  output logic [LINE_BITS-1:0] c1_readdata,
  output logic                 c1_readdata_valid,

  output logic [31:0]          mm_a,
  output logic                 mm_read,
  output logic                 mm_write,
  output logic [LINE_BITS-1:0] mm_writedata,
  input  logic [LINE_BITS-1:0] mm_readdata,
  input  logic                 mm_readdata_valid,
  input  logic                 mm_ready,

  output logic                 busy,
  output logic                 err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WD_W   = 10;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  // Latched command of the granted requester.
  typedef struct packed {
    logic                 id;
    logic                 is_rd;
    logic [ADDR_W-1:0]    a;
    logic [LINE_BITS-1:0] wd;
  } cmd_t;

  state_t          state, state_d;
  cmd_t            cmd_q, cmd_d;
  logic            last_grant, last_grant_d;
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;

  logic req0, req1, pick;

  // State register; reset abandons any in-flight transaction silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cmd_q      <= '0;
      last_grant <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      state      <= state_d;
      cmd_q      <= cmd_d;
      last_grant <= last_grant_d;
      wd_cnt     <= wd_cnt_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d           = state;
    cmd_d             = cmd_q;
    last_grant_d      = last_grant;
    wd_cnt_d          = wd_cnt;
    pick              = 1'b0;
    req0              = c0_read | c0_write;
    req1              = c1_read | c1_write;

    c0_ready          = 1'b0;
    c1_ready          = 1'b0;
    c0_readdata_valid = 1'b0;
    c1_readdata_valid = 1'b0;
    c0_readdata       = mm_readdata;
    c1_readdata       = mm_readdata;
    mm_a              = '0;
    mm_read           = 1'b0;
    mm_write          = 1'b0;
    mm_writedata      = '0;
    busy              = 1'b0;
    err               = 1'b0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          // Both requesting: favour the one not served last.
          pick        = (req0 & req1) ? ~last_grant : req1;
          cmd_d.id    = pick;
          cmd_d.is_rd = pick ? c1_read : c0_read;
          cmd_d.a     = pick ? c1_a : c0_a;
          cmd_d.wd    = pick ? c1_writedata : c0_writedata;
          state_d     = ISSUE;
        end
        if (mm_readdata_valid) err = 1'b1;
      end

      ISSUE: begin
        busy         = 1'b1;
        mm_a         = cmd_q.a;
        mm_writedata = cmd_q.wd;
        mm_read      = cmd_q.is_rd;
        mm_write     = ~cmd_q.is_rd;
        if (mm_ready) begin
          c0_ready = ~cmd_q.id;
          c1_ready = cmd_q.id;
          if (cmd_q.is_rd) begin
            state_d  = WAIT_RD;
            wd_cnt_d = '0;
          end else begin
            state_d      = IDLE;
            last_grant_d = cmd_q.id;
          end
        end
        if (mm_readdata_valid) err = 1'b1;
      end

      WAIT_RD: begin
        busy = 1'b1;
        // Timeout wins over a response arriving in the same cycle.
        if (wd_cnt == WD_LIMIT) begin
          err          = 1'b1;
          state_d      = IDLE;
          last_grant_d = cmd_q.id;
        end else if (mm_readdata_valid) begin
          c0_readdata_valid = ~cmd_q.id;
          c1_readdata_valid = cmd_q.id;
          state_d           = IDLE;
          last_grant_d      = cmd_q.id;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Every output is forced quiet while reset is asserted.
    if (!reset) begin
      c0_ready          = 1'b0;
      c1_ready          = 1'b0;
      c0_readdata_valid = 1'b0;
      c1_readdata_valid = 1'b0;
      c0_readdata       = '0;
      c1_readdata       = '0;
      mm_a              = '0;
      mm_read           = 1'b0;
      mm_write          = 1'b0;
      mm_writedata      = '0;
      busy              = 1'b0;
      err               = 1'b0;
    end
  end

endmodule

// File: tb/tb_mm_arb.sv
// -----------------------------------------------------------------------------
// tb_mm_arb : scoreboard bench for mm_arb. Stimulus pushes the expected
// pulse (ready / readdata_valid / err) into a queue; a negedge monitor pops
// and compares whenever the DUT pulses any of them.
// -----------------------------------------------------------------------------
module tb_mm_arb;

  localparam int unsigned LB = 64;
  localparam int unsigned MW = 8;

  logic          clk, reset;
  logic [31:0]   c0_a, c1_a;
  logic          c0_read, c0_write, c1_read, c1_write;
  logic [LB-1:0] c0_writedata, c1_writedata;
  logic          c0_ready, c1_ready, c0_readdata_valid, c1_readdata_valid;
  logic [LB-1:0] c0_readdata, c1_readdata;
  logic [31:0]   mm_a;
  logic          mm_read, mm_write, mm_readdata_valid, mm_ready;
  logic [LB-1:0] mm_writedata, mm_readdata;
  logic          busy, err;

  mm_arb #(.LINE_BITS(LB), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .c0_a(c0_a), .c0_read(c0_read), .c0_write(c0_write),
    .c0_writedata(c0_writedata), .c0_ready(c0_ready),
    .c0_readdata(c0_readdata), .c0_readdata_valid(c0_readdata_valid),
    .c1_a(c1_a), .c1_read(c1_read), .c1_write(c1_write),
    .c1_writedata(c1_writedata), .c1_ready(c1_ready),
    .c1_readdata(c1_readdata), .c1_readdata_valid(c1_readdata_valid),
    .mm_a(mm_a), .mm_read(mm_read), .mm_write(mm_write),
    .mm_writedata(mm_writedata), .mm_readdata(mm_readdata),
    .mm_readdata_valid(mm_readdata_valid), .mm_ready(mm_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int K_READY = 0;
  localparam int K_RV    = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int            kind;
    bit            id;
    bit            is_rd;
    logic [31:0]   a;
    logic [LB-1:0] d;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input bit id, input bit is_rd,
                      input logic [31:0] a, input logic [LB-1:0] d);
    exp_t e;
    e.kind = kind; e.id = id; e.is_rd = is_rd; e.a = a; e.d = d;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  logic [4:0] obs;
  logic [4:0] expv;
  exp_t       e_m;
  always @(negedge clk) begin
    obs = {c0_ready, c1_ready, c0_readdata_valid, c1_readdata_valid, err};
    if ((|obs) === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", 64'(obs), 64'd0);
      end else begin
        e_m = q.pop_front();
        case (e_m.kind)
          K_READY: expv = e_m.id ? 5'b01000 : 5'b10000;
          K_RV:    expv = e_m.id ? 5'b00010 : 5'b00100;
          default: expv = 5'b00001;
        endcase
        chk("pulse_kind", 64'(obs), 64'(expv));
        if (e_m.kind == K_READY) begin
          chk("mm_a_at_ready", 64'(mm_a), 64'(e_m.a));
          chk("mm_cmd_at_ready", 64'({mm_read, mm_write}), e_m.is_rd ? 64'd2 : 64'd1);
          if (!e_m.is_rd) chk("mm_wdata_at_ready", mm_writedata, e_m.d);
        end else if (e_m.kind == K_RV) begin
          chk("readdata", e_m.id ? c1_readdata : c0_readdata, e_m.d);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    c0_a = '0; c1_a = '0; c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
    c0_writedata = '0; c1_writedata = '0;
    mm_readdata = '0; mm_readdata_valid = 0; mm_ready = 0;

    // Reset: outputs quiet even with a stray response present.
    tick;
    mm_readdata_valid = 1'b1;
    tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_strobes", 64'({mm_read, mm_write}), 64'd0);
    chk("rst_mm_a", 64'(mm_a), 64'd0);
    chk("rst_mm_wdata", mm_writedata, 64'd0);
    mm_readdata_valid = 1'b0;
    tick;

    // Single read: c0, addr 0x100, response in the third WAIT_RD cycle.
    reset = 1'b1;
    c0_read = 1'b1; c0_a = 32'h100; mm_ready = 1'b1;
    tick;
    push(K_READY, 1'b0, 1'b1, 32'h100, '0);
    chk("rd_busy_issue", 64'(busy), 64'd1);
    chk("rd_mm_read", 64'({mm_read, mm_write}), 64'd2);
    chk("rd_mm_a", 64'(mm_a), 64'h100);
    tick;
    mm_ready = 1'b0;
    chk("rd_strobes_wait", 64'({mm_read, mm_write}), 64'd0);
    chk("rd_busy_wait", 64'(busy), 64'd1);
    tick;
    tick;
    mm_readdata = 64'hDEAD_BEEF_0123_4567; mm_readdata_valid = 1'b1;
    push(K_RV, 1'b0, 1'b1, '0, 64'hDEAD_BEEF_0123_4567);
    tick;
    mm_readdata_valid = 1'b0; c0_read = 1'b0;
    chk("rd_busy_done", 64'(busy), 64'd0);

    // Round robin from reset: c0, c1, c0, c1 writes back to back.
    reset = 1'b0;
    tick;
    reset = 1'b1;
    mm_ready = 1'b1;
    c0_write = 1'b1; c0_a = 32'h1000; c0_writedata = 64'hA0;
    c1_write = 1'b1; c1_a = 32'h2000; c1_writedata = 64'hA1;
    push(K_READY, 1'b0, 1'b0, 32'h1000, 64'hA0);
    push(K_READY, 1'b1, 1'b0, 32'h2000, 64'hA1);
    push(K_READY, 1'b0, 1'b0, 32'h3000, 64'hA2);
    push(K_READY, 1'b1, 1'b0, 32'h4000, 64'hA3);
    tick;                                          // ISSUE c0
    c0_a = 32'h3000; c0_writedata = 64'hA2;
    tick;                                          // IDLE, grant c1
    tick;                                          // ISSUE c1
    c1_a = 32'h4000; c1_writedata = 64'hA3;
    tick;                                          // IDLE, grant c0
    tick;                                          // ISSUE c0
    c0_write = 1'b0;
    tick;                                          // IDLE, grant c1
    tick;                                          // ISSUE c1
    c1_write = 1'b0;
    tick;
    chk("rr_busy_done", 64'(busy), 64'd0);
    chk("rr_strobes_done", 64'({mm_read, mm_write}), 64'd0);

    // c1 write stalled by mm_ready low for 5 cycles; inputs change meanwhile.
    mm_ready = 1'b0;
    c1_write = 1'b1; c1_a = 32'hABCD_0040; c1_writedata = 64'h5555_AAAA_1234_5678;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i == 2) begin
        c1_a = 32'hFFFF_FFFF; c1_writedata = '0;
      end
      chk("stall_mm_write", 64'({mm_read, mm_write}), 64'd1);
      chk("stall_mm_a", 64'(mm_a), 64'hABCD_0040);
      chk("stall_mm_wdata", mm_writedata, 64'h5555_AAAA_1234_5678);
    end
    tick;
    mm_ready = 1'b1;
    push(K_READY, 1'b1, 1'b0, 32'hABCD_0040, 64'h5555_AAAA_1234_5678);
    tick;
    mm_ready = 1'b0; c1_write = 1'b0;
    chk("stall_busy_done", 64'(busy), 64'd0);

    // Read with no response: watchdog fires after MW cycles in WAIT_RD.
    c0_read = 1'b1; c0_a = 32'h200; mm_ready = 1'b1;
    tick;
    push(K_READY, 1'b0, 1'b1, 32'h200, '0);
    for (int i = 2; i <= 9; i++) begin
      tick;
      mm_ready = 1'b0;
    end
    chk("wd_busy_before", 64'(busy), 64'd1);
    tick;
    push(K_ERR, 1'b0, 1'b0, '0, '0);
    chk("wd_busy_timeout_cycle", 64'(busy), 64'd1);
    tick;
    c0_read = 1'b0;
    chk("wd_busy_after", 64'(busy), 64'd0);

    // c1 read+write together counts as read; reset in WAIT_RD abandons it.
    c1_read = 1'b1; c1_write = 1'b1; c1_a = 32'h300; mm_ready = 1'b1;
    tick;
    push(K_READY, 1'b1, 1'b1, 32'h300, '0);
    chk("rw_is_read", 64'({mm_read, mm_write}), 64'd2);
    tick;
    mm_ready = 1'b0;
    chk("rw_wait_busy", 64'(busy), 64'd1);
    tick;
    reset = 1'b0; c1_read = 1'b0; c1_write = 1'b0;
    tick;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_strobes", 64'({mm_read, mm_write}), 64'd0);
    chk("mid_rst_mm_a", 64'(mm_a), 64'd0);
    reset = 1'b1;
    tick;
    mm_readdata = 64'h1111; mm_readdata_valid = 1'b1;
    push(K_ERR, 1'b0, 1'b0, '0, '0);
    tick;
    mm_readdata_valid = 1'b0;
    chk("late_busy", 64'(busy), 64'd0);
    tick;
    tick;

    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
